data_memory: RTL and testbench

Byte-addressed data memory that sits directly downstream of the ALU in the RV32I datapath. The ALU result is the effective address for loads and stores.
- Stores: sb/sh/sw, written with byte enables on the clock edge.
- Loads: lb/lh/lw/lbu/lhu, returned combinationally with sign/zero extension so the single-cycle writeback path closes in one cycle.
- Faults: misaligned and out-of-range accesses are detected, suppressed, and counted.

---
 rtl/data_memory_pkg.sv | 15 +
 rtl/data_memory_if.sv | 17 +
 rtl/data_memory_load_extend.sv | 28 ++
 rtl/data_memory.sv | 97 +++++++++
 tb/tb_data_memory.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared constants for the RV32I data memory
package data_memory_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  localparam int BYTE_W      = 8;
  localparam int FAULT_CNT_W = 8;

endpackage

// File: rtl/data_memory_if.sv
// rtl/data_memory_if.sv - load/store request bus between datapath and data memory
interface data_memory_if;

  logic        MemWrite;
  logic        MemRead;
  logic [2:0]  funct3;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        AddrFault;

  modport master (output MemWrite, MemRead, funct3, A, WD,
                  input  RD, AddrFault);
  modport slave  (input  MemWrite, MemRead, funct3, A, WD,
                  output RD, AddrFault);

endinterface

// File: rtl/data_memory_load_extend.sv
// rtl/data_memory_load_extend.sv - load lane select with sign/zero extension
module data_memory_load_extend
  import data_memory_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [BYTE_W-1:0]   byte_sel;
  logic [2*BYTE_W-1:0] half_sel;

  always_comb begin
    byte_sel = word[BYTE_W*offset +: BYTE_W];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    data     = '0;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'b0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'b0, half_sel};
      F3_W:    data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - byte-addressed RV32I data memory with fault detection
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  data_memory_if.slave           bus,
  output logic                   FaultSticky,
  output logic [FAULT_CNT_W-1:0] FaultCount
);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        offset;
  logic              req, out_of_range, misaligned, illegal, fault;
  logic              store_ok, load_ok;
  logic [3:0]        byte_en;
  logic [31:0]       wdata;
  logic [31:0]       ext_data;

  assign word_idx     = bus.A[ADDR_W+1:2];
  assign offset       = bus.A[1:0];
  assign req          = bus.MemWrite | bus.MemRead;
  assign out_of_range = |bus.A[31:ADDR_W+2];

  always_comb begin
    store_ok   = 1'b0;
    load_ok    = 1'b0;
    misaligned = 1'b0;
    byte_en    = 4'b0000;
    wdata      = bus.WD;
    case (bus.funct3)
      F3_B: begin
        store_ok = 1'b1;
        load_ok  = 1'b1;
        byte_en  = 4'b0001 << offset;
        wdata    = {4{bus.WD[7:0]}};
      end
      F3_H: begin
        store_ok   = 1'b1;
        load_ok    = 1'b1;
        misaligned = offset[0];
        byte_en    = offset[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{bus.WD[15:0]}};
      end
      F3_W: begin
        store_ok   = 1'b1;
        load_ok    = 1'b1;
        misaligned = |offset;
        byte_en    = 4'b1111;
      end
      F3_BU: load_ok = 1'b1;
      F3_HU: begin
        load_ok    = 1'b1;
        misaligned = offset[0];
      end
      default: ;
    endcase
  end

  assign illegal = (bus.MemWrite & ~store_ok) | (bus.MemRead & ~load_ok);
  assign fault   = req & (out_of_range | misaligned | illegal);
  assign bus.AddrFault = fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.MemWrite && !fault) begin
      for (int l = 0; l < 4; l++)
        if (byte_en[l]) mem[word_idx][BYTE_W*l +: BYTE_W] <= wdata[BYTE_W*l +: BYTE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      FaultSticky <= 1'b0;
      FaultCount  <= '0;
    end else if (fault) begin
      FaultSticky <= 1'b1;
      if (FaultCount != '1) FaultCount <= FaultCount + 1'b1;
    end
  end

  // Reads see the pre-edge array, so a same-cycle store is never bypassed.
  data_memory_load_extend u_load_extend (
    .word   (mem[word_idx]),
    .offset (offset),
    .funct3 (bus.funct3),
    .data   (ext_data)
  );

  assign bus.RD = (bus.MemRead && !fault) ? ext_data : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed vector bench for data_memory
module tb_data_memory;

  logic       clk = 1'b0;
  logic       rst;
  logic       FaultSticky;
  logic [7:0] FaultCount;
  int         n_checks = 0;
  int         n_pass   = 0;

  data_memory_if bus ();

  data_memory dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .FaultSticky (FaultSticky),
    .FaultCount  (FaultCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic        re;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        flt;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.MemWrite = we;
    bus.MemRead  = re;
    bus.funct3   = f3;
    bus.A        = a;
    bus.WD       = wd;
  endtask

  initial begin
    int exp_faults;
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0000, 32'h0,          32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 3'b010, 32'h0000_00FC, 32'h0,          32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h1122_3344,  32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0011, 32'h0000_00AA,  32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'h0000_BEEF,  32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0,          32'hBEEF_AA44, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h8000_F0FF,  32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0020, 32'h0,          32'hFFFF_FFFF, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 3'b100, 32'h0000_0020, 32'h0,          32'h0000_00FF, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h0,          32'hFFFF_8000, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 3'b101, 32'h0000_0022, 32'h0,          32'h0000_8000, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 3'b000, 32'h0000_0021, 32'h0,          32'hFFFF_FFF0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 3'b100, 32'h0000_0023, 32'h0,          32'h0000_0080, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h0000_0031, 32'hDEAD_BEEF,  32'h0000_0000, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 3'b010, 32'h0000_0030, 32'h0,          32'h0000_0000, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 3'b001, 32'h0000_0033, 32'h0,          32'h0000_0000, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h1234_5678,  32'h0000_0000, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 3'b010, 32'h0000_0000, 32'h0,          32'h0000_0000, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 3'b100, 32'h0000_0050, 32'hFFFF_FFFF,  32'h0000_0000, 1'b1};
    vecs[19] = '{1'b0, 1'b1, 3'b010, 32'h0000_0050, 32'h0,          32'h0000_0000, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 3'b011, 32'h0000_0010, 32'h0,          32'h0000_0000, 1'b1};
    vecs[21] = '{1'b0, 1'b0, 3'b010, 32'h0000_0031, 32'h0,          32'h0000_0000, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 3'b001, 32'h0000_0010, 32'h0,          32'hFFFF_AA44, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 3'b010, 32'h0000_0012, 32'h0,          32'h0000_0000, 1'b1};

    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("reset_sticky", {31'b0, FaultSticky}, 32'h0);
    check("reset_count", {24'b0, FaultCount}, 32'h0);

    exp_faults = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].re, vecs[i].f3, vecs[i].a, vecs[i].wd);
      #2;
      check($sformatf("vec%0d_rd", i), bus.RD, vecs[i].rd);
      check($sformatf("vec%0d_fault", i), {31'b0, bus.AddrFault}, {31'b0, vecs[i].flt});
      if (vecs[i].flt) exp_faults++;
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    #2;
    check("table_sticky", {31'b0, FaultSticky}, 32'h1);
    check("table_count", {24'b0, FaultCount}, exp_faults);

    // same-cycle read and write returns old data
    drive(1'b1, 1'b1, 3'b010, 32'h40, 32'h5);
    #2;
    check("rw_old_rd", bus.RD, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b010, 32'h40, 32'h0);
    #2;
    check("rw_new_rd", bus.RD, 32'h5);
    @(negedge clk);
    drive(1'b1, 1'b1, 3'b010, 32'h41, 32'h7);
    #2;
    check("rw_fault", {31'b0, bus.AddrFault}, 32'h1);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b010, 32'h40, 32'h0);
    #2;
    check("rw_fault_once", {24'b0, FaultCount}, exp_faults + 1);
    check("rw_fault_nowrite", bus.RD, 32'h5);

    @(negedge clk);
    drive(1'b0, 1'b1, 3'b010, 32'h1, 32'h0);
    repeat (300) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    #2;
    check("sat_count", {24'b0, FaultCount}, 32'd255);

    // reset wins over a concurrent store; reads still reflect the array
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 3'b010, 32'h40, 32'h9);
    #2;
    check("rst_rd_live", bus.RD, 32'h5);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 3'b010, 32'h40, 32'h0);
    #2;
    check("post_rst_rd", bus.RD, 32'h0);
    check("post_rst_count", {24'b0, FaultCount}, 32'h0);
    check("post_rst_sticky", {31'b0, FaultSticky}, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
    #2;
    check("post_rst_rd10", bus.RD, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
